// File: rtl/ham74_serial_encoder_pkg.sv
// -----------------------------------------------------------------------------
// ham74_pkg
// Shared definitions for the serial Hamming(7,4) encoder and its decoder tests.
//   DATA_W / CW_W / BIT_IDX_W : nibble, codeword and bit-index widths
//   cw_t                      : codeword, index 0 = codeword position 1
//   enc_state_t               : transmit FSM states
//   ham74_encode()            : nibble -> codeword
//   ham74_err_mask()          : single-bit flip mask for error injection
// -----------------------------------------------------------------------------
package ham74_pkg;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned CW_W      = 7;
  localparam int unsigned BIT_IDX_W = 3;

  // Index of the final codeword bit (position 7).
  localparam logic [BIT_IDX_W-1:0] LAST_IDX = 3'd6;

  typedef logic [CW_W-1:0] cw_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } enc_state_t;

  // Positions 1..7 = p1,p2,d1,p3,d2,d3,d4 with d1 = nibble[0].
  function automatic cw_t ham74_encode(input logic [DATA_W-1:0] nibble);
    logic d1, d2, d3, d4;
    cw_t  cw;
    d1 = nibble[0];
    d2 = nibble[1];
    d3 = nibble[2];
    d4 = nibble[3];
    cw = {d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4};
    return cw;
  endfunction

  // One-hot mask on codeword position pos (1..7); pos = 0 or arm = 0 gives no flip.
  function automatic cw_t ham74_err_mask(input logic arm, input logic [BIT_IDX_W-1:0] pos);
    cw_t m;
    m = {CW_W{1'b0}};
    for (int i = 0; i < CW_W; i++) begin
      m[i] = arm & (pos == BIT_IDX_W'(i + 1));
    end
    return m;
  endfunction

endpackage

// File: rtl/ham74_serial_encoder_if.sv
// -----------------------------------------------------------------------------
// ham74_serial_encoder_if
// Nibble input handshake of the serial Hamming(7,4) encoder.
//   in_data  : nibble to encode (d1 = in_data[0])
//   in_valid : in_data valid (source -> encoder)
//   in_ready : encoder can accept (encoder -> source)
// Modports: master = nibble source, slave = encoder.
// -----------------------------------------------------------------------------
interface ham74_serial_encoder_if;
  import ham74_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ham74_serial_encoder_fifo.sv
// -----------------------------------------------------------------------------
// ham74_nibble_fifo
// Synchronous nibble FIFO, synchronous active-low reset.
//   i_clk, i_rst_n : clock, reset (pointers and level cleared)
//   i_push, i_data : write request and nibble; ignored while full
//   i_pop          : read request; ignored while empty
//   o_data         : head entry (valid when !o_empty)
//   o_full, o_empty, o_level : occupancy
// FIFO_DEPTH must be a power of 2, at least 2.
// -----------------------------------------------------------------------------
module ham74_nibble_fifo
  import ham74_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_push,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_pop,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_level == LW'(FIFO_DEPTH));
  assign o_empty = (r_level == LW'(0));
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  // A full FIFO refuses the push even when a pop happens on the same edge.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Pointer and occupancy registers; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_level  <= LW'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

endmodule

// File: rtl/ham74_serial_encoder.sv
// -----------------------------------------------------------------------------
// ham74_serial_encoder
// Buffers 4-bit nibbles, encodes each to a Hamming(7,4) codeword and shifts it
// out LSB (position 1) first, frames back-to-back with no idle gap.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_ena          : clock enable; low freezes everything and drops in_ready
//   io_bus         : nibble handshake (slave modport)
//   o_tx_bit       : serial codeword bit (IDLE_LEVEL when idle)
//   o_tx_sof       : high while o_tx_bit carries position 1
//   o_tx_active    : frame in flight
//   o_bit_idx      : current position 0..6, 0 when idle
//   o_fifo_level   : buffered nibbles
// Optional build macro HAM_ERR_INJECT_EN adds i_err_arm / i_err_pos: when armed
// on the edge a codeword is latched, position i_err_pos (1..7) is inverted for
// that frame only.
// -----------------------------------------------------------------------------
module ham74_serial_encoder
  import ham74_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_ena,
  ham74_serial_encoder_if.slave       io_bus,
`ifdef HAM_ERR_INJECT_EN
  input  logic                        i_err_arm,
  input  logic [BIT_IDX_W-1:0]        i_err_pos,
`endif
  output logic                        o_tx_bit,
  output logic                        o_tx_sof,
  output logic                        o_tx_active,
  output logic [BIT_IDX_W-1:0]        o_bit_idx,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

  enc_state_t            r_state;
  enc_state_t            w_state_nxt;
  cw_t                   r_cw;
  cw_t                   w_cw_nxt;
  cw_t                   w_cw_enc;
  logic [BIT_IDX_W-1:0]  r_bit_idx;
  logic [BIT_IDX_W-1:0]  w_bit_idx_nxt;
  logic [BIT_IDX_W-1:0]  w_bit_idx_inc;
  logic                  r_tx_bit;
  logic                  w_tx_bit_nxt;
  logic                  r_tx_sof;
  logic                  w_tx_sof_nxt;
  logic                  r_tx_active;
  logic                  w_tx_active_nxt;
  logic                  w_load;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_W-1:0]     w_head;

  // Reset is folded into in_ready so the source sees 0 throughout reset.
  assign io_bus.in_ready = i_ena & i_rst_n & ~w_full;
  assign w_push          = io_bus.in_valid & io_bus.in_ready;

  ham74_nibble_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (io_bus.in_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

`ifdef HAM_ERR_INJECT_EN
  assign w_cw_enc = ham74_encode(w_head) ^ ham74_err_mask(i_err_arm, i_err_pos);
`else
  assign w_cw_enc = ham74_encode(w_head);
`endif

  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  // Next-state and next-output logic of the transmit FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_cw_nxt        = r_cw;
    w_bit_idx_nxt   = r_bit_idx;
    w_tx_bit_nxt    = r_tx_bit;
    w_tx_sof_nxt    = r_tx_sof;
    w_tx_active_nxt = r_tx_active;
    w_load          = 1'b0;
    w_pop           = 1'b0;
    if (i_ena) begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_load = 1'b0;
          end
        end
        SHIFT: begin
          if (r_bit_idx == LAST_IDX) begin
            if (!w_empty) begin
              // Next frame starts on the very next edge: no gap.
              w_load = 1'b1;
            end else begin
              w_state_nxt     = IDLE;
              w_bit_idx_nxt   = 3'd0;
              w_tx_bit_nxt    = IDLE_LEVEL;
              w_tx_sof_nxt    = 1'b0;
              w_tx_active_nxt = 1'b0;
            end
          end else begin
            w_bit_idx_nxt = w_bit_idx_inc;
            w_tx_bit_nxt  = r_cw[w_bit_idx_inc];
            w_tx_sof_nxt  = 1'b0;
          end
        end
        default: begin
          w_state_nxt     = IDLE;
          w_bit_idx_nxt   = 3'd0;
          w_tx_bit_nxt    = IDLE_LEVEL;
          w_tx_sof_nxt    = 1'b0;
          w_tx_active_nxt = 1'b0;
        end
      endcase
      if (w_load) begin
        w_pop           = 1'b1;
        w_state_nxt     = SHIFT;
        w_cw_nxt        = w_cw_enc;
        w_bit_idx_nxt   = 3'd0;
        w_tx_bit_nxt    = w_cw_enc[0];
        w_tx_sof_nxt    = 1'b1;
        w_tx_active_nxt = 1'b1;
      end else begin
        w_pop = 1'b0;
      end
    end else begin
      // Disabled: hold everything, the frame resumes where it stopped.
      w_pop  = 1'b0;
      w_load = 1'b0;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cw        <= {CW_W{1'b0}};
      r_bit_idx   <= 3'd0;
      r_tx_bit    <= IDLE_LEVEL;
      r_tx_sof    <= 1'b0;
      r_tx_active <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cw        <= w_cw_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_tx_bit    <= w_tx_bit_nxt;
      r_tx_sof    <= w_tx_sof_nxt;
      r_tx_active <= w_tx_active_nxt;
    end
  end

  assign o_tx_bit    = r_tx_bit;
  assign o_tx_sof    = r_tx_sof;
  assign o_tx_active = r_tx_active;
  assign o_bit_idx   = r_bit_idx;

endmodule

// File: tb/tb_ham74_serial_encoder.sv
// -----------------------------------------------------------------------------
// tb_ham74_serial_encoder
// Self-checking bench: a monitor pushes the expected 7 bits of every accepted
// nibble into a scoreboard queue and compares them against the serial output
// on each enabled edge; directed sequences cover latency, back-to-back frames,
// FIFO full, clock-enable hold, mid-frame reset and (optionally) error injection.
// -----------------------------------------------------------------------------
module tb_ham74_serial_encoder;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic        IDLE_LEVEL = 1'b0;

  typedef struct packed {
    logic       b;
    logic       sof;
    logic [2:0] idx;
  } exp_bit_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       tx_bit;
  logic       tx_sof;
  logic       tx_active;
  logic [2:0] bit_idx;
  logic [2:0] fifo_level;
`ifdef HAM_ERR_INJECT_EN
  logic       err_arm = 1'b0;
  logic [2:0] err_pos = 3'd0;
`endif

  ham74_serial_encoder_if bus ();

  int n_checks = 0;
  int n_fails  = 0;
  exp_bit_t sb_q[$];

  ham74_serial_encoder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ena        (ena),
    .io_bus       (bus),
`ifdef HAM_ERR_INJECT_EN
    .i_err_arm    (err_arm),
    .i_err_pos    (err_pos),
`endif
    .o_tx_bit     (tx_bit),
    .o_tx_sof     (tx_sof),
    .o_tx_active  (tx_active),
    .o_bit_idx    (bit_idx),
    .o_fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Independent codeword model, index 0 = position 1.
  function automatic logic [6:0] model_cw(input logic [3:0] n);
    logic d1, d2, d3, d4, p1, p2, p3;
    d1 = n[0]; d2 = n[1]; d3 = n[2]; d4 = n[3];
    p1 = d1 ^ d2 ^ d4;
    p2 = d1 ^ d3 ^ d4;
    p3 = d2 ^ d3 ^ d4;
    return {d4, d3, d2, p3, d1, p2, p1};
  endfunction

  // Monitor / scoreboard.
  logic       m_rst, m_ena, m_push;
  logic [3:0] m_data;
  int         m_qb;
  logic [6:0] m_cw;
  exp_bit_t   m_e;
  always @(posedge clk) begin
    m_rst  = rst_n;
    m_ena  = ena;
    m_push = bus.in_valid & bus.in_ready;
    m_data = bus.in_data;
    m_qb   = sb_q.size();
    m_cw   = model_cw(m_data);
`ifdef HAM_ERR_INJECT_EN
    if (err_arm && err_pos != 3'd0) m_cw[err_pos - 3'd1] = ~m_cw[err_pos - 3'd1];
`endif
    #1;
    if (!m_rst) begin
      sb_q.delete();
      check_value("rst_tx_bit", tx_bit, IDLE_LEVEL);
      check_value("rst_tx_sof", tx_sof, 0);
      check_value("rst_tx_active", tx_active, 0);
      check_value("rst_bit_idx", bit_idx, 0);
      check_value("rst_fifo_level", fifo_level, 0);
    end else if (m_ena) begin
      if (tx_active) begin
        if (sb_q.size() == 0) begin
          check_value("unexpected_frame", 1, 0);
        end else begin
          m_e = sb_q.pop_front();
          check_value("tx_bit", tx_bit, m_e.b);
          check_value("tx_sof", tx_sof, m_e.sof);
          check_value("bit_idx", bit_idx, m_e.idx);
        end
      end else begin
        check_value("idle_tx_bit", tx_bit, IDLE_LEVEL);
        check_value("idle_tx_sof", tx_sof, 0);
        check_value("idle_bit_idx", bit_idx, 0);
        check_value("frame_gap", m_qb, 0);
      end
      if (m_push) begin
        for (int k = 0; k < 7; k++) begin
          sb_q.push_back('{b: m_cw[k], sof: (k == 0), idx: 3'(k)});
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [3:0] d);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) check_value("send_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idx(input logic [2:0] v);
    int n;
    n = 0;
    while (!(tx_active && bit_idx == v) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_value("wait_idx_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((tx_active || fifo_level != 3'd0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_value("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  logic [6:0] bits;

  initial begin
    bus.in_data  = 4'h0;
    bus.in_valid = 1'b0;
    ena          = 1'b1;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check_value("ready_in_reset", bus.in_ready, 0);
    rst_n = 1'b1;
    #1;
    check_value("ready_after_reset", bus.in_ready, 1);
    @(negedge clk);

    // Single frame and one-edge latency.
    send(4'b1011);
    check_value("latency_active", tx_active, 0);
    @(negedge clk);
    check_value("first_sof", tx_sof, 1);
    for (int i = 0; i < 7; i++) begin
      bits[i] = tx_bit;
      @(negedge clk);
    end
    check_value("frame_1011", bits, 7'b1010101);
    check_value("end_active", tx_active, 0);
    check_value("end_tx_bit", tx_bit, IDLE_LEVEL);
    drain();

    // Back-to-back frames (gap checked by the monitor).
    send(4'h0);
    send(4'hF);
    drain();

    // FIFO full: blocked push on a pop edge, accepted the next edge.
    send(4'h1);
    send(4'h2);
    send(4'h3);
    send(4'h4);
    send(4'h5);
    check_value("full_level", fifo_level, 4);
    check_value("full_ready", bus.in_ready, 0);
    wait_idx(3'd6);
    bus.in_data  = 4'h7;
    bus.in_valid = 1'b1;
    #1;
    check_value("full_pop_ready", bus.in_ready, 0);
    @(negedge clk);
    check_value("after_pop_level", fifo_level, 3);
    check_value("after_pop_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_value("accepted_level", fifo_level, 4);
    drain();

    // Clock-enable hold mid-frame.
    send(4'h6);
    wait_idx(3'd3);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_value("hold_tx_bit", tx_bit, model_cw(4'h6) >> 3 & 7'd1);
      check_value("hold_bit_idx", bit_idx, 3);
      check_value("hold_ready", bus.in_ready, 0);
    end
    ena = 1'b1;
    drain();

    // Reset mid-frame with two nibbles queued.
    send(4'h9);
    send(4'h3);
    send(4'hC);
    wait_idx(3'd4);
    check_value("pre_rst_level", fifo_level, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_value("post_rst_active", tx_active, 0);
    check_value("post_rst_level", fifo_level, 0);

`ifdef HAM_ERR_INJECT_EN
    // Error injection on one frame only.
    err_arm = 1'b1;
    err_pos = 3'd3;
    send(4'b1011);
    @(negedge clk);
    err_arm = 1'b0;
    err_pos = 3'd0;
    check_value("inj_sof", tx_sof, 1);
    send(4'b1011);
    drain();
`endif

    // Random nibbles with occasional enable drops.
    for (int i = 0; i < 12; i++) begin
      send(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) begin
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
      end
    end
    drain();
    check_value("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
